// File: rtl/rca_bist_checker.sv
// BIST sequencer and response checker for a fault-injected full-adder array.
// Walks all eight {a,b,cin} patterns, waits SETTLE cycles for the array to
// settle, then compares every cell's sum/carry against the golden full-adder
// response. It accumulates a sticky fault map, a saturating mismatch count and
// the first failing pattern.
module rca_bist_checker #(
  parameter int N_CELLS = 4,
  parameter int SETTLE  = 1,
  parameter int CNT_W   = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic                   stop_on_fail,
  input  logic [N_CELLS-1:0]     adder_sums,
  input  logic [N_CELLS-1:0]     adder_carrys,
  output logic [2:0]             pat_idx,
  output logic                   busy,
  output logic                   done,
  output logic                   pass,
  output logic [2*N_CELLS-1:0]   comp,
  output logic [2*N_CELLS-1:0]   fault_map,
  output logic [CNT_W-1:0]       fault_cnt,
  output logic [2:0]             first_fail_idx,
  output logic                   first_fail_valid
);

  localparam int MW = 2 * N_CELLS;
  // Up to 32 mismatch bits per compare, so a 6-bit popcount is enough.
  localparam int PW = 6;
  localparam logic [3:0] SETTLE_L = 4'(SETTLE);

  typedef enum logic [2:0] {
    S_IDLE,
    S_APPLY,
    S_WAIT,
    S_CHECK,
    S_DONE
  } state_t;

  state_t state, state_nxt;

  logic [3:0]    settle_cnt;
  logic          stop_lat;
  logic          exp_sum;
  logic          exp_carry;
  logic [MW-1:0] mismatch;
  logic          any_mm;
  logic          run_end;
  logic          accept;

  // Number of set bits in a mismatch vector.
  function automatic logic [PW-1:0] popcount(input logic [MW-1:0] v);
    logic [PW-1:0] n;
    n = '0;
    for (int i = 0; i < MW; i++) begin
      n = n + {{(PW-1){1'b0}}, v[i]};
    end
    return n;
  endfunction

  // Counter add that clamps at the all-ones value instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] acc,
                                               input logic [PW-1:0]    inc);
    logic [CNT_W+PW:0] s;
    s = {{(PW+1){1'b0}}, acc} + {{(CNT_W+1){1'b0}}, inc};
    if (s > {{(PW+1){1'b0}}, {CNT_W{1'b1}}}) begin
      return {CNT_W{1'b1}};
    end
    return s[CNT_W-1:0];
  endfunction

  // Golden full-adder response and the per-bit mismatch against the array.
  always_comb begin
    exp_sum   = ^pat_idx;
    exp_carry = (pat_idx[2] & pat_idx[1]) | (pat_idx[2] & pat_idx[0]) |
                (pat_idx[1] & pat_idx[0]);
    mismatch  = {({N_CELLS{exp_carry}} ^ adder_carrys),
                 ({N_CELLS{exp_sum}}   ^ adder_sums)};
    any_mm    = |mismatch;
    run_end   = (pat_idx == 3'd7) || (stop_lat && any_mm);
    accept    = start && ((state == S_IDLE) || (state == S_DONE));
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE, S_DONE: begin
        if (start) state_nxt = S_APPLY;
      end
      S_APPLY: begin
        state_nxt = (SETTLE_L != 4'd0) ? S_WAIT : S_CHECK;
      end
      S_WAIT: begin
        if (settle_cnt == 4'd1) state_nxt = S_CHECK;
      end
      S_CHECK: begin
        state_nxt = run_end ? S_DONE : S_APPLY;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Run bookkeeping: pattern stepping, settle timer and result accumulation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pat_idx          <= '0;
      busy             <= 1'b0;
      done             <= 1'b0;
      pass             <= 1'b0;
      comp             <= '0;
      fault_map        <= '0;
      fault_cnt        <= '0;
      first_fail_idx   <= '0;
      first_fail_valid <= 1'b0;
      settle_cnt       <= '0;
      stop_lat         <= 1'b0;
    end else begin
      if (accept) begin
        pat_idx          <= '0;
        busy             <= 1'b1;
        done             <= 1'b0;
        pass             <= 1'b0;
        comp             <= '0;
        fault_map        <= '0;
        fault_cnt        <= '0;
        first_fail_idx   <= '0;
        first_fail_valid <= 1'b0;
        stop_lat         <= stop_on_fail;
      end else begin
        case (state)
          S_APPLY: begin
            settle_cnt <= SETTLE_L;
          end
          S_WAIT: begin
            settle_cnt <= settle_cnt - 4'd1;
          end
          S_CHECK: begin
            comp      <= mismatch;
            fault_map <= fault_map | mismatch;
            fault_cnt <= sat_add(fault_cnt, popcount(mismatch));
            if (any_mm && !first_fail_valid) begin
              first_fail_idx   <= pat_idx;
              first_fail_valid <= 1'b1;
            end
            if (run_end) begin
              busy <= 1'b0;
              done <= 1'b1;
              pass <= ((fault_map | mismatch) == '0);
            end else begin
              pat_idx <= pat_idx + 3'd1;
            end
          end
          default: begin
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_rca_bist_checker.sv
// Bench for rca_bist_checker: four instances cover the default build, a
// narrow saturating counter, SETTLE=0 and SETTLE=3. A fault injector drives
// the adder inputs; a scoreboard holds the expected result of each run.
module tb_rca_bist_checker;

  localparam int NI = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic sof = 1'b0;
  int   mode = 0;

  logic       start_v [NI];
  logic [2:0] pat_v   [NI];
  logic       busy_v  [NI];
  logic       done_v  [NI];
  logic       pass_v  [NI];
  logic [7:0] comp_v  [NI];
  logic [7:0] map_v   [NI];
  logic [7:0] cnt_v   [NI];
  logic [2:0] ffi_v   [NI];
  logic       ffv_v   [NI];
  logic [3:0] sum_v   [NI];
  logic [3:0] car_v   [NI];

  typedef struct {
    logic [7:0] map;
    logic [7:0] comp;
    int         cnt;
    logic [2:0] ffi;
    logic       ffv;
    logic       pass;
    logic [2:0] pat;
    int         cycles;
  } exp_t;

  exp_t sb[$];
  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  // Adder-array stand-in: {carrys, sums} for pattern p under fault mode m.
  // 0 good, 1 cell2 sum stuck-at-0, 2 cell0 carry stuck-at-1, 3 all inverted.
  function automatic logic [7:0] inject(input int m, input logic [2:0] p);
    logic [1:0] g;
    logic [3:0] s, c;
    g = {1'b0, p[2]} + {1'b0, p[1]} + {1'b0, p[0]};
    s = {4{g[0]}};
    c = {4{g[1]}};
    if (m == 1) s[2] = 1'b0;
    if (m == 2) c[0] = 1'b1;
    if (m == 3) begin
      s = ~s;
      c = ~c;
    end
    return {c, s};
  endfunction

  function automatic int settle_of(input int i);
    return (i == 2) ? 0 : (i == 3) ? 3 : 1;
  endfunction

  function automatic int cmax_of(input int i);
    return (i == 1) ? 31 : 255;
  endfunction

  for (genvar g = 0; g < NI; g++) begin : g_dut
    localparam int S  = (g == 2) ? 0 : (g == 3) ? 3 : 1;
    localparam int CW = (g == 1) ? 5 : 8;
    logic [CW-1:0] fc;
    logic [7:0]    fo;
    assign fo       = inject(mode, pat_v[g]);
    assign car_v[g] = fo[7:4];
    assign sum_v[g] = fo[3:0];
    assign cnt_v[g] = 8'(fc);
    rca_bist_checker #(.N_CELLS(4), .SETTLE(S), .CNT_W(CW)) u_dut (
      .clk              (clk),
      .rst_n            (rst_n),
      .start            (start_v[g]),
      .stop_on_fail     (sof),
      .adder_sums       (sum_v[g]),
      .adder_carrys     (car_v[g]),
      .pat_idx          (pat_v[g]),
      .busy             (busy_v[g]),
      .done             (done_v[g]),
      .pass             (pass_v[g]),
      .comp             (comp_v[g]),
      .fault_map        (map_v[g]),
      .fault_cnt        (fc),
      .first_fail_idx   (ffi_v[g]),
      .first_fail_valid (ffv_v[g])
    );
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference run: golden from arithmetic a+b+cin against injected outputs.
  function automatic exp_t model(input int m, input bit stop, input int inst);
    exp_t e;
    logic [2:0] pv;
    logic [1:0] g;
    logic [7:0] fo, mm;
    int pc;
    e.map = '0; e.comp = '0; e.cnt = 0; e.ffi = '0; e.ffv = 1'b0;
    e.pass = 1'b0; e.pat = '0; e.cycles = 0;
    for (int p = 0; p < 8; p++) begin
      pv = 3'(p);
      g  = {1'b0, pv[2]} + {1'b0, pv[1]} + {1'b0, pv[0]};
      fo = inject(m, pv);
      for (int c = 0; c < 4; c++) begin
        mm[c]     = fo[c] != g[0];
        mm[c + 4] = fo[c + 4] != g[1];
      end
      pc = 0;
      for (int b = 0; b < 8; b++) pc += int'(mm[b]);
      e.comp = mm;
      e.map  = e.map | mm;
      e.cnt  = (e.cnt + pc > cmax_of(inst)) ? cmax_of(inst) : e.cnt + pc;
      if (mm != 0 && !e.ffv) begin
        e.ffi = pv;
        e.ffv = 1'b1;
      end
      e.cycles += settle_of(inst) + 2;
      e.pat = pv;
      if (stop && mm != 0) break;
    end
    e.pass = (e.map == 0);
    return e;
  endfunction

  task automatic run(input int inst, input int m, input bit stop, input bit poke);
    exp_t e;
    int cyc;
    bit seen;
    logic [7:0] map_hold;
    mode = m;
    sof  = stop;
    sb.push_back(model(m, stop, inst));
    @(negedge clk);
    start_v[inst] = 1'b1;
    @(posedge clk);
    #1;
    start_v[inst] = 1'b0;
    sof = 1'b0;
    check("busy_after_start", 32'(busy_v[inst]), 32'd1);
    check("map_cleared", 32'(map_v[inst]), 32'd0);
    cyc  = 0;
    seen = 1'b0;
    for (int k = 0; k < 200 && !seen; k++) begin
      @(posedge clk);
      #1;
      cyc++;
      start_v[inst] = (poke && cyc == 5);
      if (done_v[inst]) seen = 1'b1;
    end
    start_v[inst] = 1'b0;
    e = sb.pop_front();
    check("done_seen", 32'(seen), 32'd1);
    check("run_cycles", 32'(cyc), 32'(e.cycles));
    check("busy_at_done", 32'(busy_v[inst]), 32'd0);
    check("pass", 32'(pass_v[inst]), 32'(e.pass));
    check("fault_map", 32'(map_v[inst]), 32'(e.map));
    check("comp", 32'(comp_v[inst]), 32'(e.comp));
    check("fault_cnt", 32'(cnt_v[inst]), 32'(e.cnt));
    check("first_fail_idx", 32'(ffi_v[inst]), 32'(e.ffi));
    check("first_fail_valid", 32'(ffv_v[inst]), 32'(e.ffv));
    check("pat_idx_end", 32'(pat_v[inst]), 32'(e.pat));
    map_hold = map_v[inst];
    repeat (3) @(posedge clk);
    #1;
    check("done_held", 32'(done_v[inst]), 32'd1);
    check("map_held", 32'(map_v[inst]), 32'(map_hold));
  endtask

  initial begin
    for (int i = 0; i < NI; i++) start_v[i] = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_pat", 32'(pat_v[0]), 32'd0);
    check("rst_busy", 32'(busy_v[0]), 32'd0);
    check("rst_done", 32'(done_v[0]), 32'd0);
    check("rst_pass", 32'(pass_v[0]), 32'd0);
    check("rst_vectors", {comp_v[0], map_v[0], cnt_v[0], 4'(ffi_v[0]), 4'(ffv_v[0])}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    run(0, 0, 1'b0, 1'b1);   // fault-free, 24 cycles, start poked mid-run
    run(0, 1, 1'b0, 1'b0);   // cell 2 sum stuck-at-0
    check("sa0_map_const", 32'(map_v[0]), 32'h04);
    run(0, 2, 1'b0, 1'b0);   // cell 0 carry stuck-at-1
    run(0, 2, 1'b1, 1'b0);   // same with stop_on_fail: 3 cycles
    run(0, 0, 1'b0, 1'b0);   // restart from DONE clears old results
    run(1, 3, 1'b0, 1'b0);   // all inverted, CNT_W=5 saturates at 31
    check("sat_const", 32'(cnt_v[1]), 32'd31);

    // Reset asserted while waiting on pattern 3.
    mode = 1;
    @(negedge clk);
    start_v[0] = 1'b1;
    @(posedge clk);
    #1;
    start_v[0] = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    check("mid_pat", 32'(pat_v[0]), 32'd3);
    check("mid_map", 32'(map_v[0]), 32'h04);
    rst_n = 1'b0;
    #1;
    check("arst_busy", 32'(busy_v[0]), 32'd0);
    check("arst_pat", 32'(pat_v[0]), 32'd0);
    check("arst_vectors", {comp_v[0], map_v[0], cnt_v[0], 4'(ffi_v[0]), 4'(ffv_v[0])}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("idle_after_rst", {31'd0, busy_v[0] | done_v[0]}, 32'd0);
    run(0, 0, 1'b0, 1'b0);

    run(2, 0, 1'b0, 1'b0);   // SETTLE=0: 16 cycles
    run(3, 0, 1'b0, 1'b0);   // SETTLE=3: 40 cycles

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/rca_bist_checker.md
Name: rca_bist_checker

Overview:
- Parametrised built-in self-test sequencer and response checker for ripple-carry adder fault experiments. It generalises the single-pattern golden lookup into a full test run.
- Steps through all 8 full-adder input patterns, {a,b,cin} = pat_idx[2:0], applied identically to N_CELLS isolated full-adder cells. After a settle delay it compares each cell's sum/carry against internally computed golden values.
- Accumulates a sticky per-output fault map, a saturating mismatch count and the first failing pattern.
- Sits between the fault-injected adder array and the result/report logic.

Parameters:
- N_CELLS, 4, number of full-adder cells checked in parallel (1..16).
- SETTLE, 1, wait cycles between pattern apply and compare (0..15).
- CNT_W, 8, width of fault_cnt; saturates at 2^CNT_W-1.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  begin a run; sampled only in IDLE or DONE.
- stop_on_fail  in  1  abort the run at the first pattern with any mismatch; sampled at start.
- adder_sums  in  N_CELLS  sum output of each cell under test.
- adder_carrys  in  N_CELLS  carry output of each cell under test.
- pat_idx  out  3  current pattern index; bit2=a, bit1=b, bit0=cin.
- busy  out  1  high from start accept until DONE.
- done  out  1  high in DONE; held until the next start.
- pass  out  1  valid while done: 1 iff fault_map==0.
- comp  out  2*N_CELLS  registered mismatch vector of the last compare, {carry mismatches, sum mismatches}, cell 0 in the LSB of each half.
- fault_map  out  2*N_CELLS  sticky OR of comp over the run, same bit order.
- fault_cnt  out  CNT_W  total mismatching bits over the run, saturating.
- first_fail_idx  out  3  pat_idx of the first compare with comp!=0.
- first_fail_valid  out  1  first_fail_idx is meaningful.

Behaviour:
- Reset (async assert, sync release): state=IDLE. All outputs 0: pat_idx, busy, done, pass, comp, fault_map, fault_cnt, first_fail_idx, first_fail_valid.
- Golden values per cell: exp_sum = ^pat_idx; exp_carry = majority(pat_idx[2], pat_idx[1], pat_idx[0]). comp = {exp_carry repeated N_CELLS ^ adder_carrys, exp_sum repeated N_CELLS ^ adder_sums}.
- FSM states: IDLE, APPLY, WAIT, CHECK, DONE.
- IDLE/DONE with start=1:
  - Clear fault_map, fault_cnt, comp, first_fail_idx, first_fail_valid, done, pass; pat_idx=0.
  - Latch stop_on_fail; busy=1; go to APPLY.
  - In DONE, start=0 holds all results.
- APPLY: 1 cycle. pat_idx is stable. Load the settle counter with SETTLE. Go to WAIT if SETTLE>0, else CHECK.
- WAIT: decrement the settle counter; go to CHECK when it reaches 1. WAIT lasts exactly SETTLE cycles.
- CHECK: 1 cycle. Register comp. fault_map |= comp. fault_cnt += popcount(comp), clamped at max.
  - If comp!=0 and !first_fail_valid: capture pat_idx and set first_fail_valid.
  - Go to DONE if pat_idx==7, or if latched stop_on_fail and comp!=0. Otherwise pat_idx+1 and go to APPLY.
- DONE: busy=0, done=1. pass = (fault_map==0), computed on the CHECK->DONE transition. pat_idx holds its last value.
- Run length from the start-accept edge to done rising: 8*(SETTLE+2) cycles for a full run; k*(SETTLE+2) when aborting at the k-th pattern.
- start while busy: ignored; no restart and no effect.
- Adder inputs are sampled only in CHECK. Glitches elsewhere are ignored.
- pat_idx wrap: never increments past 7. The run ends at 7.
- fault_cnt saturation: holds at max; fault_map and first-fail capture continue normally.
- rst_n low mid-run: immediate return to the reset values; a new start is required.

Test Plan:
- Fault-free model, N_CELLS=4, SETTLE=1, start pulse -> busy for 24 cycles, then done=1, pass=1, fault_map=0, fault_cnt=0, first_fail_valid=0, pat_idx=7.
- Cell 2 sum stuck-at-0 -> mismatches at idx 1,2,4,7. Result: fault_map=8'h04, fault_cnt=4, first_fail_idx=1, pass=0.
- Cell 0 carry stuck-at-1 -> mismatches at idx 0,1,2,4. Result: fault_map=8'h10, fault_cnt=4, first_fail_idx=0. Repeat with stop_on_fail=1 -> done after 3 cycles, pat_idx=0, fault_cnt=1.
- All 8 outputs inverted, CNT_W=5 -> 64 raw mismatches; fault_cnt saturates at 31, fault_map=8'hFF, first_fail_idx=0.
- Assert rst_n mid-WAIT at idx 3 -> all outputs 0, state IDLE. A following fault-free run completes in 24 cycles with pass=1. start pulses during busy are ignored; a restart from DONE clears the old fault_map.
- SETTLE=0 fault-free -> done after 16 cycles. Vary SETTLE=3 -> 40 cycles.
